// File: rtl/m6502_timing_sequencer.sv
// 6502 timing sequencer: T-state ring, instruction register, start-up and RDY.
// Optional watchdog recovery at T7 is enabled by M6502_TIMING_WATCHDOG_EN.
module m6502_timing_sequencer #(
  parameter int          RESET_CYCLES = 7,
  parameter logic [7:0]  RESET_OPCODE = 8'hEA,
  parameter int          COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ready,
  input  logic [7:0]             data_in,
  input  logic                   timing_reset,
  output logic [7:0]             timing,
  output logic [7:0]             opcode,
  output logic                   decode_reset,
  output logic                   sync,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic                   illegal
);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_STARTUP = 2'd1,
    S_RUN     = 2'd2
  } state_e;

  localparam logic [7:0] RC8 = 8'(RESET_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE =
    {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q;
  logic [7:0]             timing_q;
  logic [7:0]             opcode_q;
  logic                   dec_rst_q;
  logic                   sync_q;
  logic [COUNT_WIDTH-1:0] instr_q;
  logic                   illegal_q;
  logic [7:0]             stup_q;

  logic [7:0]             stup_d;
  logic [COUNT_WIDTH-1:0] instr_d;
  logic [7:0]             shift_d;

  // Next-value helpers for the start-up counter, fetch counter and ring.
  always_comb begin
    stup_d  = stup_q + 8'd1;
    instr_d = instr_q + CNT_ONE;
    shift_d = {timing_q[6:0], 1'b0};
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_RESET;
      timing_q  <= 8'h00;
      opcode_q  <= RESET_OPCODE;
      dec_rst_q <= 1'b1;
      sync_q    <= 1'b0;
      instr_q   <= '0;
      illegal_q <= 1'b0;
      stup_q    <= 8'd0;
    end else begin
      illegal_q <= 1'b0;
      unique case (state_q)
        S_RESET, S_STARTUP: begin
          stup_q <= stup_d;
          if (stup_d == RC8) begin
            state_q   <= S_RUN;
            timing_q  <= 8'h01;
            dec_rst_q <= 1'b0;
            sync_q    <= 1'b1;
          end else begin
            state_q <= S_STARTUP;
          end
        end
        S_RUN: begin
          if (ready) begin
            unique case (1'b1)
              timing_q[0]: begin
                opcode_q <= data_in;
                timing_q <= 8'h02;
                instr_q  <= instr_d;
                sync_q   <= 1'b0;
              end
              timing_q[7]: begin
                if (timing_reset) begin
                  timing_q <= 8'h01;
                  sync_q   <= 1'b1;
                end else begin
`ifdef M6502_TIMING_WATCHDOG_EN
                  timing_q  <= 8'h01;
                  sync_q    <= 1'b1;
                  illegal_q <= 1'b1;
`else
                  timing_q <= 8'h80;
                  sync_q   <= 1'b0;
`endif
                end
              end
              default: begin
                if (timing_reset) begin
                  timing_q <= 8'h01;
                  sync_q   <= 1'b1;
                end else begin
                  timing_q <= shift_d;
                  sync_q   <= 1'b0;
                end
              end
            endcase
          end
        end
        default: begin
          state_q <= S_RESET;
        end
      endcase
    end
  end

  assign timing       = timing_q;
  assign opcode       = opcode_q;
  assign decode_reset = dec_rst_q;
  assign sync         = sync_q;
  assign instr_count  = instr_q;
`ifdef M6502_TIMING_WATCHDOG_EN
  assign illegal      = illegal_q;
`else
  assign illegal      = 1'b0;
`endif

endmodule

// File: tb/tb_m6502_timing_sequencer.sv
// Directed bench for m6502_timing_sequencer with a tiny NOP/LDA#/JMP decode.
// Second instance (RESET_CYCLES=1, COUNT_WIDTH=4) covers counter wrap.
module tb_m6502_timing_sequencer;

  logic        clk;
  logic        rst_n;
  logic        rst_w;
  logic        rdy;
  logic [7:0]  din;

  logic [7:0]  t_a;
  logic [7:0]  op_a;
  logic        dr_a;
  logic        sy_a;
  logic [15:0] cnt_a;
  logic        ill_a;
  logic        tr_a;

  logic [7:0]  t_w;
  logic [7:0]  op_w;
  logic        dr_w;
  logic        sy_w;
  logic [3:0]  cnt_w;
  logic        ill_w;
  logic        tr_w;

  int checks;
  int errors;

  assign tr_a = (t_a[1] & (op_a == 8'hEA || op_a == 8'hA9)) |
                (t_a[2] & (op_a == 8'h4C));
  assign tr_w = (t_w[1] & (op_w == 8'hEA || op_w == 8'hA9)) |
                (t_w[2] & (op_w == 8'h4C));

  m6502_timing_sequencer #(
    .RESET_CYCLES(7),
    .RESET_OPCODE(8'hEA),
    .COUNT_WIDTH(16)
  ) u_dut (
    .clock(clk),
    .reset(rst_n),
    .ready(rdy),
    .data_in(din),
    .timing_reset(tr_a),
    .timing(t_a),
    .opcode(op_a),
    .decode_reset(dr_a),
    .sync(sy_a),
    .instr_count(cnt_a),
    .illegal(ill_a)
  );

  m6502_timing_sequencer #(
    .RESET_CYCLES(1),
    .RESET_OPCODE(8'hEA),
    .COUNT_WIDTH(4)
  ) u_wrap (
    .clock(clk),
    .reset(rst_w),
    .ready(rdy),
    .data_in(din),
    .timing_reset(tr_w),
    .timing(t_w),
    .opcode(op_w),
    .decode_reset(dr_w),
    .sync(sy_w),
    .instr_count(cnt_w),
    .illegal(ill_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] v_din [13];
  logic       v_rdy [13];
  logic [7:0] v_t   [13];
  logic [15:0] v_c  [13];
  logic [7:0] v_op  [13];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    rst_w  = 1'b0;
    rdy    = 1'b1;
    din    = 8'hEA;

    v_din = '{8'hEA, 8'h00, 8'hA9, 8'h00, 8'h4C, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h4C, 8'h4C, 8'h00};
    v_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    v_t   = '{8'h02, 8'h01, 8'h02, 8'h01, 8'h02, 8'h02, 8'h02,
              8'h02, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04};
    v_c   = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd3,
              16'd3, 16'd3, 16'd3, 16'd3, 16'd4, 16'd4};
    v_op  = '{8'hEA, 8'hEA, 8'hA9, 8'hA9, 8'h4C, 8'h4C, 8'h4C,
              8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C};

    // reset state
    repeat (3) tick();
    chk("rst_timing", 32'(t_a), 32'h00);
    chk("rst_opcode", 32'(op_a), 32'hEA);
    chk("rst_decrst", 32'(dr_a), 32'h1);
    chk("rst_sync", 32'(sy_a), 32'h0);
    chk("rst_count", 32'(cnt_a), 32'h0);
    chk("rst_illegal", 32'(ill_a), 32'h0);

    // start-up sequence
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("stup_timing", 32'(t_a), 32'h00);
      chk("stup_decrst", 32'(dr_a), 32'h1);
    end
    tick();
    chk("run_timing", 32'(t_a), 32'h01);
    chk("run_decrst", 32'(dr_a), 32'h0);
    chk("run_sync", 32'(sy_a), 32'h1);
    chk("run_opcode", 32'(op_a), 32'hEA);
    chk("run_count", 32'(cnt_a), 32'h0);

    // program stream, stall during JMP T1, JMP into T2
    for (int i = 0; i < 13; i++) begin
      din = v_din[i];
      rdy = v_rdy[i];
      tick();
      chk("prog_timing", 32'(t_a), 32'(v_t[i]));
      chk("prog_count", 32'(cnt_a), 32'(v_c[i]));
      chk("prog_opcode", 32'(op_a), 32'(v_op[i]));
      chk("prog_sync", 32'(sy_a), 32'(v_t[i] == 8'h01));
    end

    // reset during JMP T2
    rst_n = 1'b0;
    tick();
    chk("mid_timing", 32'(t_a), 32'h00);
    chk("mid_opcode", 32'(op_a), 32'hEA);
    chk("mid_count", 32'(cnt_a), 32'h0);
    chk("mid_decrst", 32'(dr_a), 32'h1);
    chk("mid_sync", 32'(sy_a), 32'h0);

    // second start-up with RDY low, which start-up ignores
    rst_n = 1'b1;
    rdy   = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("stup2_timing", 32'(t_a), 32'h00);
    end
    tick();
    chk("stup2_timing7", 32'(t_a), 32'h01);
    chk("stup2_decrst", 32'(dr_a), 32'h0);
    rdy = 1'b1;

    // undecoded opcode runs up to T7
    din = 8'h02;
    tick();
    chk("und_fetch_t", 32'(t_a), 32'h02);
    chk("und_fetch_op", 32'(op_a), 32'h02);
    chk("und_fetch_cnt", 32'(cnt_a), 32'h1);
    din = 8'h00;
    for (int k = 2; k <= 7; k++) begin
      tick();
      chk("und_ring", 32'(t_a), 32'h1 << k);
    end
    tick();
`ifdef M6502_TIMING_WATCHDOG_EN
    chk("wd_timing", 32'(t_a), 32'h01);
    chk("wd_illegal", 32'(ill_a), 32'h1);
    chk("wd_opcode", 32'(op_a), 32'h02);
    din = 8'hEA;
    tick();
    chk("wd_next_t", 32'(t_a), 32'h02);
    chk("wd_next_ill", 32'(ill_a), 32'h0);
    chk("wd_next_cnt", 32'(cnt_a), 32'h2);
`else
    chk("sat_timing", 32'(t_a), 32'h80);
    chk("sat_illegal", 32'(ill_a), 32'h0);
    din = 8'hEA;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sat_hold_t", 32'(t_a), 32'h80);
      chk("sat_hold_ill", 32'(ill_a), 32'h0);
      chk("sat_hold_cnt", 32'(cnt_a), 32'h1);
    end
`endif

    // counter wrap on the narrow instance, RESET_CYCLES=1
    din   = 8'hEA;
    rst_w = 1'b1;
    tick();
    chk("wrap_rc1_t", 32'(t_w), 32'h01);
    chk("wrap_rc1_dr", 32'(dr_w), 32'h0);
    chk("wrap_rc1_cnt", 32'(cnt_w), 32'h0);
    for (int m = 2; m <= 34; m++) begin
      tick();
      if (m == 32) begin
        chk("wrap16_cnt", 32'(cnt_w), 32'h0);
        chk("wrap16_t", 32'(t_w), 32'h02);
      end
      if (m == 34) begin
        chk("wrap17_cnt", 32'(cnt_w), 32'h1);
        chk("wrap17_t", 32'(t_w), 32'h02);
      end
    end
    chk("wrap_illegal", 32'(ill_w), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
